// File: rtl/fc_layer_pkg.sv
// fc_layer_pkg: FSM state type, activation names and result post-processing for fc_layer_tdm (FC_ROUND_EN selects round-half-up)
package fc_layer_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, DRAIN} fc_state_e;

    localparam logic [31:0] ACT_RELU = "relu";
    localparam logic [31:0] ACT_NONE = "none";

    // Adds the aligned bias, drops FRAC_W fraction bits, saturates to data_w signed, then optional ReLU.
    function automatic logic signed [63:0] sat_act(
        input logic signed [63:0] acc,
        input logic signed [63:0] bias,
        input int                 frac_w,
        input int                 data_w,
        input logic               relu
    );
        logic signed [63:0] s, hi, lo;
        s = acc + (bias <<< frac_w);
`ifdef FC_ROUND_EN
        if (frac_w > 0) s = s + (64'sd1 <<< (frac_w - 1));
`endif
        s  = s >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        s  = (s > hi) ? hi : (s < lo) ? lo : s;
        return (relu && s < 0) ? 64'sd0 : s;
    endfunction

endpackage

// File: rtl/fc_layer_tdm_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane with synchronous clear and enable
module fc_mac_lane #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 42
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d, acc_q;

    // next accumulator value: clear has priority over accumulate
    always_comb begin
        prod  = x * w;
        acc_d = clr ? '0 : en ? acc_q + ACC_W'(prod) : acc_q;
    end

    // accumulator register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) acc_q <= '0;
        else       acc_q <= acc_d;

    assign acc = acc_q;

endmodule

// File: rtl/fc_layer_tdm.sv
// fc_layer_tdm: time-multiplexed fully-connected layer, LANES MAC lanes over ceil(NN/LANES) passes; define FC_ROUND_EN for round-half-up
module fc_layer_tdm
    import fc_layer_pkg::*;
#(
    parameter int NN     = 30,
    parameter int NUM_IN = 784,
    parameter int DATA_W = 16,
    parameter int INT_W  = 4,
    parameter int LANES  = 8,
    parameter     ACT    = "relu",
    localparam int NW    = NN > 1 ? $clog2(NN) : 1,
    localparam int IW    = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              w_we,
    input  logic [NW-1:0]     w_neuron,
    input  logic [IW-1:0]     w_index,
    input  logic [DATA_W-1:0] w_data,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_data,
    output logic              busy,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [NW-1:0]     o_index,
    output logic              o_last
);

    localparam int   FRAC_W = DATA_W - INT_W;
    localparam int   PASSES = (NN + LANES - 1) / LANES;
    localparam int   DEPTH  = PASSES * NUM_IN;
    localparam int   AW     = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int   CW     = $clog2(NUM_IN + 1);
    localparam int   PW     = PASSES > 1 ? $clog2(PASSES) : 1;
    localparam int   LW     = LANES > 1 ? $clog2(LANES) : 1;
    localparam int   ACC_W  = 2 * DATA_W + IW;
    localparam logic RELU   = (ACT == ACT_RELU);

    fc_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           pass_q, pass_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic [DATA_W-1:0]       res_q [LANES];
    logic [DATA_W-1:0]       res_d [LANES];
    logic [DATA_W-1:0]       x_buf [NUM_IN];
    logic [DATA_W-1:0]       bias_mem [NN];
    logic [DATA_W-1:0]       x_rd_q;
    logic signed [ACC_W-1:0] acc [LANES];
    logic                    x_hs, o_hs, mac_rd, mac_clr, mac_en;
    int                      o_num;

    assign busy    = state_q != IDLE;
    assign x_ready = rstn && (state_q == IDLE || state_q == LOAD);
    assign o_valid = state_q == DRAIN;
    assign o_data  = res_q[lane_q];
    assign o_index = NW'(o_num);
    assign o_last  = o_valid && o_num == NN - 1;

    // handshakes and MAC-phase strobes; cycle 0 of MAC clears, cycles 1..NUM_IN accumulate
    always_comb begin
        o_num   = int'(pass_q) * LANES + int'(lane_q);
        x_hs    = x_valid && x_ready;
        o_hs    = o_valid && o_ready;
        mac_rd  = state_q == MAC && int'(cnt_q) < NUM_IN;
        mac_clr = state_q == MAC && cnt_q == '0;
        mac_en  = state_q == MAC && cnt_q != '0;
    end

    // FSM next state: load inputs, then per pass MAC / BIAS / DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                state_d = x_hs ? LOAD : IDLE;
                cnt_d   = x_hs ? CW'(1) : '0;
            end
            LOAD: if (x_hs) begin
                state_d = int'(cnt_q) == NUM_IN - 1 ? MAC : LOAD;
                cnt_d   = int'(cnt_q) == NUM_IN - 1 ? '0 : cnt_q + CW'(1);
            end
            MAC: begin
                state_d = int'(cnt_q) == NUM_IN ? BIAS : MAC;
                cnt_d   = int'(cnt_q) == NUM_IN ? '0 : cnt_q + CW'(1);
            end
            BIAS: begin
                state_d = DRAIN;
                lane_d  = '0;
            end
            DRAIN: if (o_hs) begin
                if (o_num == NN - 1) begin
                    state_d = IDLE;
                    pass_d  = '0;
                    lane_d  = '0;
                end else if (int'(lane_q) == LANES - 1) begin
                    state_d = MAC;
                    pass_d  = pass_q + PW'(1);
                    lane_d  = '0;
                end else begin
                    lane_d  = lane_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // lane results are captured once per pass in BIAS; lanes beyond NN-1 get zero bias and are never shown
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            res_d[j] = res_q[j];
            if (state_q == BIAS)
                res_d[j] = DATA_W'(sat_act(64'(acc[j]),
                    (int'(pass_q) * LANES + j < NN) ?
                        64'($signed(bias_mem[(int'(pass_q) * LANES + j < NN) ? int'(pass_q) * LANES + j : 0])) : 64'sd0,
                    FRAC_W, DATA_W, RELU));
        end
    end

    // control state, counters and lane output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            lane_q  <= '0;
            for (int j = 0; j < LANES; j++) res_q[j] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            lane_q  <= lane_d;
            res_q   <= res_d;
        end
    end

    // input buffer, bias store and registered input read: plain storage, survives reset
    always_ff @(posedge clk) begin
        if (x_hs) x_buf[IW'(cnt_q)] <= x_data;
        if (b_we && state_q == IDLE && int'(w_neuron) < NN) bias_mem[w_neuron] <= b_data;
        if (mac_rd) x_rd_q <= x_buf[IW'(cnt_q)];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [DATA_W-1:0] w_mem [DEPTH];
        logic [DATA_W-1:0] w_rd_q;
        logic [AW-1:0]     w_addr, r_addr;
        logic              w_hit;

        // bank j holds neurons j, j+LANES, ...; one NUM_IN-deep slice per pass
        always_comb begin
            w_hit  = w_we && state_q == IDLE && int'(w_neuron) < NN && int'(w_index) < NUM_IN
                     && int'(w_neuron) % LANES == j;
            w_addr = AW'((int'(w_neuron) / LANES) * NUM_IN + int'(w_index));
            r_addr = AW'(int'(pass_q) * NUM_IN + int'(cnt_q));
        end

        // weight bank: write port from the load interface, synchronous read during MAC
        always_ff @(posedge clk) begin
            if (w_hit)  w_mem[w_addr] <= w_data;
            if (mac_rd) w_rd_q <= w_mem[r_addr];
        end

        fc_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .clk (clk),
            .rstn(rstn),
            .clr (mac_clr),
            .en  (mac_en),
            .x   (x_rd_q),
            .w   (w_rd_q),
            .acc (acc[j])
        );
    end

endmodule

// File: tb/tb_fc_layer_tdm.sv
// tb_fc_layer_tdm: directed bench for fc_layer_tdm; dut_a NN=4/LANES=2/relu, dut_b NN=5/LANES=4/none
module tb_fc_layer_tdm;

`ifdef FC_ROUND_EN
    localparam logic [15:0] RND = 16'h0001;
`else
    localparam logic [15:0] RND = 16'h0000;
`endif

    logic clk = 0, rstn = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] w_data = 0, b_data = 0, x_data = 0;
    logic [1:0]  w_idx = 0;
    logic        wa_we = 0, ba_we = 0, xa_valid = 0, oa_ready = 0;
    logic [1:0]  wa_n = 0;
    logic        a_busy, xa_ready, oa_valid, oa_last;
    logic [15:0] oa_data;
    logic [1:0]  oa_index;
    logic        wb_we = 0, bb_we = 0, xb_valid = 0, ob_ready = 0;
    logic [2:0]  wb_n = 0;
    logic        b_busy, xb_ready, ob_valid, ob_last;
    logic [15:0] ob_data;
    logic [2:0]  ob_index;

    fc_layer_tdm #(.NN(4), .NUM_IN(4), .DATA_W(16), .INT_W(4), .LANES(2), .ACT("relu")) dut_a (
        .clk(clk), .rstn(rstn), .w_we(wa_we), .w_neuron(wa_n), .w_index(w_idx), .w_data(w_data),
        .b_we(ba_we), .b_data(b_data), .busy(a_busy), .x_valid(xa_valid), .x_ready(xa_ready),
        .x_data(x_data), .o_valid(oa_valid), .o_ready(oa_ready), .o_data(oa_data),
        .o_index(oa_index), .o_last(oa_last));

    fc_layer_tdm #(.NN(5), .NUM_IN(4), .DATA_W(16), .INT_W(4), .LANES(4), .ACT("none")) dut_b (
        .clk(clk), .rstn(rstn), .w_we(wb_we), .w_neuron(wb_n), .w_index(w_idx), .w_data(w_data),
        .b_we(bb_we), .b_data(b_data), .busy(b_busy), .x_valid(xb_valid), .x_ready(xb_ready),
        .x_data(x_data), .o_valid(ob_valid), .o_ready(ob_ready), .o_data(ob_data),
        .o_index(ob_index), .o_last(ob_last));

    int          vecs = 0, errs = 0, t0 = 0;
    string       tname = "reset";
    logic [15:0] xv [4];
    logic [15:0] exp_d [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s/%s: observed %h expected %h", tname, tag, got, exp);
        end
    endtask

    // mode 0: every weight = val; 1: diagonal = val; 2: column 0 = val; others 0
    task automatic fill_w(input bit sel, input int mode, input logic [15:0] val);
        for (int n = 0; n < (sel ? 5 : 4); n++)
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (sel) begin wb_we = 1; wb_n = 3'(n); end
                else begin wa_we = 1; wa_n = 2'(n); end
                w_idx  = 2'(i);
                w_data = (mode == 0 || (mode == 1 && n == i) || (mode == 2 && i == 0)) ? val : 16'h0000;
            end
        @(negedge clk);
        wa_we = 0;
        wb_we = 0;
    endtask

    task automatic w_one(input bit sel, input int n, input int i, input logic [15:0] d);
        @(negedge clk);
        if (sel) begin wb_we = 1; wb_n = 3'(n); end
        else begin wa_we = 1; wa_n = 2'(n); end
        w_idx  = 2'(i);
        w_data = d;
        @(negedge clk);
        wa_we = 0;
        wb_we = 0;
    endtask

    task automatic set_b(input bit sel, input int n, input logic [15:0] d);
        @(negedge clk);
        if (sel) begin bb_we = 1; wb_n = 3'(n); end
        else begin ba_we = 1; wa_n = 2'(n); end
        b_data = d;
        @(negedge clk);
        ba_we = 0;
        bb_we = 0;
    endtask

    task automatic send(input bit sel);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("x_ready_load", 32'(sel ? xb_ready : xa_ready), 1);
            if (sel) xb_valid = 1; else xa_valid = 1;
            x_data = xv[i];
        end
        t0 = cyc;
        @(negedge clk);
        xa_valid = 0;
        xb_valid = 0;
    endtask

    // backpressure pattern over successive valid cycles: ready 1,0,0,1,...
    task automatic collect(input bit sel, input int n, input bit bp);
        int          got = 0, vc = 0, budget = 0;
        logic        v, r, lst, xr;
        logic [15:0] d;
        logic [2:0]  idx;
        while (got < n && budget < 300) begin
            @(negedge clk);
            budget++;
            v   = sel ? ob_valid : oa_valid;
            d   = sel ? ob_data : oa_data;
            idx = sel ? ob_index : {1'b0, oa_index};
            lst = sel ? ob_last : oa_last;
            xr  = sel ? xb_ready : xa_ready;
            if (v) begin
                if (vc == 0) chk("latency", 32'(cyc - t0), 7);
                chk("o_data", 32'(d), 32'(exp_d[got]));
                chk("o_index", 32'(idx), 32'(got));
                chk("o_last", 32'(lst), 32'(got == n - 1));
                chk("x_ready_drain", 32'(xr), 0);
                r = bp ? (vc % 4 == 0 || vc % 4 == 3) : 1'b1;
                if (sel) ob_ready = r; else oa_ready = r;
                vc++;
                if (r) got++;
            end
        end
        if (got < n) begin
            vecs++;
            errs++;
            $error("FAIL %s/timeout: observed %0d outputs expected %0d", tname, got, n);
        end
        @(negedge clk);
        oa_ready = 0;
        ob_ready = 0;
        repeat (4) @(negedge clk);
        chk("o_valid_after", 32'(sel ? ob_valid : oa_valid), 0);
        chk("busy_after", 32'(sel ? b_busy : a_busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("a_busy", 32'(a_busy), 0);
        chk("a_x_ready", 32'(xa_ready), 0);
        chk("a_o_valid", 32'(oa_valid), 0);
        chk("a_o_data", 32'(oa_data), 0);
        chk("a_o_index", 32'(oa_index), 0);
        chk("a_o_last", 32'(oa_last), 0);
        chk("b_x_ready", 32'(xb_ready), 0);
        chk("b_o_valid", 32'(ob_valid), 0);
        rstn = 1;
        @(negedge clk);
        chk("a_idle_x_ready", 32'(xa_ready), 1);

        tname = "identity";
        fill_w(0, 1, 16'h1000);
        for (int n = 0; n < 4; n++) set_b(0, n, 16'h0000);
        xv    = '{16'h1000, 16'h2000, 16'hF000, 16'h0800};
        exp_d = '{16'h1000, 16'h2000, 16'h0000, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0};
        send(0);
        collect(0, 4, 0);

        tname = "backpressure";
        send(0);
        collect(0, 4, 1);

        tname = "write_gating";
        send(0);
        chk("busy_mac", 32'(a_busy), 1);
        w_one(0, 0, 0, 16'h7000);
        set_b(0, 1, 16'h4000);
        collect(0, 4, 0);
        tname = "write_gating_rerun";
        send(0);
        collect(0, 4, 0);

        tname = "reset_mid_drain";
        send(0);
        for (int i = 0; i < 20 && !oa_valid; i++) @(negedge clk);
        oa_ready = 1;
        @(negedge clk);
        oa_ready = 0;
        chk("pre_valid", 32'(oa_valid), 1);
        chk("pre_index", 32'(oa_index), 1);
        rstn = 0;
        #1;
        chk("o_valid", 32'(oa_valid), 0);
        chk("busy", 32'(a_busy), 0);
        chk("o_index", 32'(oa_index), 0);
        chk("o_data", 32'(oa_data), 0);
        @(negedge clk);
        rstn = 1;
        tname = "after_reset";
        send(0);
        collect(0, 4, 0);

        tname = "sat_pos";
        fill_w(0, 0, 16'h7FFF);
        xv    = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        exp_d = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0};
        send(0);
        collect(0, 4, 0);

        tname = "partial_pass";
        fill_w(1, 0, 16'h0000);
        for (int n = 0; n < 5; n++) set_b(1, n, 16'(n * 16'h1000));
        xv    = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        exp_d = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0, 16'h0, 16'h0};
        send(1);
        collect(1, 5, 0);

        tname = "sat_neg";
        fill_w(1, 0, 16'h8000);
        for (int n = 0; n < 5; n++) set_b(1, n, 16'h0000);
        xv    = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        exp_d = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0};
        send(1);
        collect(1, 5, 1);

        tname = "rounding";
        fill_w(1, 2, 16'h0800);
        xv    = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        exp_d = '{RND, RND, RND, RND, RND, 16'h0, 16'h0, 16'h0};
        send(1);
        collect(1, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
